// File: rtl/motor_pkg.sv
// Shared encodings for the motor drive sequencer: direction codes, FSM states,
// duty width and the clamped ramp step used by the duty ramp.
package motor_pkg;

    localparam int DUTY_W = 8;

    localparam logic [1:0] DIR_STOP  = 2'b00;
    localparam logic [1:0] DIR_FWD   = 2'b01;
    localparam logic [1:0] DIR_REV   = 2'b10;
    localparam logic [1:0] DIR_BRAKE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_RAMP_DOWN,
        ST_DEAD,
        ST_BRAKE
    } state_t;

    // Move cur one step toward tgt without overshooting; 9-bit math so nothing wraps.
    function automatic logic [DUTY_W-1:0] ramp_step(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt,
                                                    input logic [DUTY_W:0]   step);
        logic [DUTY_W:0] sum;
        logic [DUTY_W:0] gap;
        sum = {1'b0, cur} + step;
        gap = {1'b0, cur} - {1'b0, tgt};
        if (cur < tgt) return (sum > {1'b0, tgt}) ? tgt : sum[DUTY_W-1:0];
        if (gap > step) return cur - step[DUTY_W-1:0];
        return tgt;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Slow timebase: one-cycle tick every TICK_DIV clocks (TICK_DIV >= 2).
module tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick  = (cnt_q == LAST);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/motor_drive_sequencer.sv
// One H-bridge channel: command handshake, duty ramp, dead-time before reversal.
// Optional command watchdog enabled by defining MOTOR_WDOG_EN.
module motor_drive_sequencer
    import motor_pkg::*;
#(
    parameter int TICK_DIV   = 100000,
    parameter int DEAD_TICKS = 4,
    parameter int RAMP_STEP  = 8,
    parameter int WDOG_TICKS = 500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_dir,
    input  logic [DUTY_W-1:0] cmd_duty,
    output logic              in1,
    output logic              in2,
    output logic              pwm,
    output logic              busy,
    output logic              wdog_trip
);

    localparam int DW = $clog2(DEAD_TICKS + 1);
    localparam logic [DW-1:0]     DEAD_LAST = DW'(DEAD_TICKS - 1);
    localparam logic [DUTY_W:0]   STEP9     = (DUTY_W + 1)'(RAMP_STEP);

    state_t            state_q, state_d;
    logic [1:0]        cur_dir_q, cur_dir_d;
    logic [1:0]        pend_dir_q, pend_dir_d;
    logic [DUTY_W-1:0] pend_duty_q, pend_duty_d;
    logic [DUTY_W-1:0] duty_cur_q, duty_cur_d;
    logic [DUTY_W-1:0] duty_tgt_q, duty_tgt_d;
    logic [DW-1:0]     dead_q, dead_d;
    logic [DUTY_W-1:0] pwm_cnt_q;
    logic              in1_q, in2_q, pwm_q;
    logic              in1_d, in2_d, pwm_d, drive_d;
    logic              tick, accept, wdog_fire;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_DRIVE) || (state_q == ST_BRAKE);
    assign busy      = (state_q == ST_RAMP_DOWN) || (state_q == ST_DEAD);
    assign accept    = cmd_valid && cmd_ready;

`ifdef MOTOR_WDOG_EN
    localparam int WW = $clog2(WDOG_TICKS + 1);
    logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
    logic          wdog_trip_q, wdog_trip_d;

    assign wdog_fire = (state_q == ST_DRIVE) && !accept && tick &&
                       (wdog_cnt_q == WW'(WDOG_TICKS - 1));

    always_comb begin
        wdog_cnt_d  = wdog_cnt_q;
        wdog_trip_d = wdog_trip_q;
        if (accept || wdog_fire)                 wdog_cnt_d = '0;
        else if (state_q == ST_DRIVE && tick)    wdog_cnt_d = wdog_cnt_q + 1'b1;
        if (wdog_fire)                           wdog_trip_d = 1'b1;
        else if (accept && cmd_dir != DIR_STOP)  wdog_trip_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt_q  <= '0;
            wdog_trip_q <= 1'b0;
        end else begin
            wdog_cnt_q  <= wdog_cnt_d;
            wdog_trip_q <= wdog_trip_d;
        end
    end

    assign wdog_trip = wdog_trip_q;
`else
    assign wdog_fire = 1'b0;
    assign wdog_trip = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cur_dir_d   = cur_dir_q;
        pend_dir_d  = pend_dir_q;
        pend_duty_d = pend_duty_q;
        duty_cur_d  = duty_cur_q;
        duty_tgt_d  = duty_tgt_q;
        dead_d      = dead_q;

        // The ramp step on a tick applies even when a command changes state this cycle.
        if (tick && (state_q == ST_DRIVE || state_q == ST_RAMP_DOWN))
            duty_cur_d = ramp_step(duty_cur_q, duty_tgt_q, STEP9);

        case (state_q)
            ST_IDLE: begin
                if (accept && (cmd_dir == DIR_FWD || cmd_dir == DIR_REV)) begin
                    state_d    = ST_DRIVE;
                    cur_dir_d  = cmd_dir;
                    duty_tgt_d = cmd_duty;
                    duty_cur_d = '0;
                end else if (accept && cmd_dir == DIR_BRAKE) begin
                    state_d    = ST_DEAD;
                    pend_dir_d = DIR_BRAKE;
                    dead_d     = '0;
                end
            end
            ST_DRIVE: begin
                if (accept) begin
                    if (cmd_dir == cur_dir_q) begin
                        duty_tgt_d = cmd_duty;
                    end else if (cmd_dir == DIR_BRAKE) begin
                        state_d    = ST_DEAD;
                        pend_dir_d = DIR_BRAKE;
                        duty_cur_d = '0;
                        dead_d     = '0;
                    end else begin
                        state_d     = ST_RAMP_DOWN;
                        pend_dir_d  = cmd_dir;
                        pend_duty_d = cmd_duty;
                        duty_tgt_d  = '0;
                    end
                end else if (wdog_fire) begin
                    state_d    = ST_RAMP_DOWN;
                    pend_dir_d = DIR_STOP;
                    duty_tgt_d = '0;
                end
            end
            ST_RAMP_DOWN: begin
                if (tick && duty_cur_q == '0) begin
                    state_d = ST_DEAD;
                    dead_d  = '0;
                end
            end
            ST_DEAD: begin
                if (tick) begin
                    if (dead_q == DEAD_LAST) begin
                        case (pend_dir_q)
                            DIR_STOP:  state_d = ST_IDLE;
                            DIR_BRAKE: state_d = ST_BRAKE;
                            default: begin
                                state_d    = ST_DRIVE;
                                cur_dir_d  = pend_dir_q;
                                duty_tgt_d = pend_duty_q;
                                duty_cur_d = '0;
                            end
                        endcase
                    end else begin
                        dead_d = dead_q + 1'b1;
                    end
                end
            end
            ST_BRAKE: begin
                if (accept && cmd_dir != DIR_BRAKE) begin
                    state_d     = ST_DEAD;
                    pend_dir_d  = cmd_dir;
                    pend_duty_d = cmd_duty;
                    dead_d      = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bridge outputs are decoded from next state so they leave flops glitch-free.
    always_comb begin
        drive_d = (state_d == ST_DRIVE) || (state_d == ST_RAMP_DOWN);
        in1_d   = (drive_d && cur_dir_d == DIR_FWD) || (state_d == ST_BRAKE);
        in2_d   = (drive_d && cur_dir_d == DIR_REV) || (state_d == ST_BRAKE);
        pwm_d   = (state_d == ST_BRAKE) || (drive_d && (pwm_cnt_q < duty_cur_d));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_dir_q   <= DIR_STOP;
            pend_dir_q  <= DIR_STOP;
            pend_duty_q <= '0;
            duty_cur_q  <= '0;
            duty_tgt_q  <= '0;
            dead_q      <= '0;
            pwm_cnt_q   <= '0;
            in1_q       <= 1'b0;
            in2_q       <= 1'b0;
            pwm_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_dir_q   <= cur_dir_d;
            pend_dir_q  <= pend_dir_d;
            pend_duty_q <= pend_duty_d;
            duty_cur_q  <= duty_cur_d;
            duty_tgt_q  <= duty_tgt_d;
            dead_q      <= dead_d;
            pwm_cnt_q   <= pwm_cnt_q + 1'b1;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            pwm_q       <= pwm_d;
        end
    end

    assign in1 = in1_q;
    assign in2 = in2_q;
    assign pwm = pwm_q;

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// Bench for motor_drive_sequencer: directed scenarios plus random commands
// checked cycle by cycle against a behavioural model of the channel.
module tb_motor_drive_sequencer;

    localparam int TD = 4;
    localparam int DT = 2;
    localparam int RS = 64;
    localparam int WT = 10;
`ifdef MOTOR_WDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    localparam int M_OFF = 0, M_RUN = 1, M_SLOW = 2, M_GAP = 3, M_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_dir = 2'b00;
    logic [7:0] cmd_duty = 8'd0;
    logic       cmd_ready, in1, in2, pwm, busy, wdog_trip;

    motor_drive_sequencer #(
        .TICK_DIV(TD), .DEAD_TICKS(DT), .RAMP_STEP(RS), .WDOG_TICKS(WT)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_duty(cmd_duty), .in1(in1), .in2(in2),
        .pwm(pwm), .busy(busy), .wdog_trip(wdog_trip)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model of the channel: mode, direction, duty, gap ticks, watchdog ticks, clock count.
    int m_mode, m_dir, m_pend, m_pdut, m_cur, m_tgt, m_gap, m_wd, m_cyc;
    bit m_trip;
    logic [5:0] exp_o;
    bit last_tick, acc_dut;
    int pre_mode;

    wire [5:0] obs = {in1, in2, pwm, busy, cmd_ready, wdog_trip};

    task automatic step();
        bit tk, acc, fire;
        int ocyc, ocur, omode;
        bit drv;
        tk       = (m_cyc % TD) == TD - 1;
        acc      = cmd_valid && (m_mode == M_OFF || m_mode == M_RUN || m_mode == M_HOLD);
        acc_dut  = cmd_valid && cmd_ready;
        pre_mode = m_mode;
        @(posedge clk);
        if (rst) begin
            m_mode = M_OFF; m_dir = 0; m_pend = 0; m_pdut = 0; m_cur = 0; m_tgt = 0;
            m_gap = 0; m_wd = 0; m_cyc = 0; m_trip = 0;
            exp_o = 6'b000010;
        end else begin
            ocyc = m_cyc; ocur = m_cur; omode = m_mode;
            m_cyc++;
            fire = 0;
            if (WD_ON) begin
                if (acc) m_wd = 0;
                else if (omode == M_RUN && tk) begin
                    m_wd++;
                    if (m_wd >= WT) begin fire = 1; m_wd = 0; end
                end
                if (acc && cmd_dir != 2'd0) m_trip = 0;
                if (fire) m_trip = 1;
            end
            if (tk && (omode == M_RUN || omode == M_SLOW))
                m_cur = (m_cur < m_tgt) ? ((m_cur + RS > m_tgt) ? m_tgt : m_cur + RS)
                                        : ((m_cur - RS < m_tgt) ? m_tgt : m_cur - RS);
            case (omode)
                M_OFF: if (acc) begin
                    if (cmd_dir == 2'd1 || cmd_dir == 2'd2) begin
                        m_mode = M_RUN; m_dir = cmd_dir; m_tgt = cmd_duty; m_cur = 0;
                    end else if (cmd_dir == 2'd3) begin
                        m_mode = M_GAP; m_pend = 3; m_gap = 0;
                    end
                end
                M_RUN: if (acc) begin
                    if (cmd_dir == m_dir) m_tgt = cmd_duty;
                    else if (cmd_dir == 2'd3) begin
                        m_mode = M_GAP; m_pend = 3; m_cur = 0; m_gap = 0;
                    end else begin
                        m_mode = M_SLOW; m_pend = cmd_dir; m_pdut = cmd_duty; m_tgt = 0;
                    end
                end else if (fire) begin
                    m_mode = M_SLOW; m_pend = 0; m_tgt = 0;
                end
                M_SLOW: if (tk && ocur == 0) begin m_mode = M_GAP; m_gap = 0; end
                M_GAP: if (tk) begin
                    m_gap++;
                    if (m_gap == DT) begin
                        if (m_pend == 0) m_mode = M_OFF;
                        else if (m_pend == 3) m_mode = M_HOLD;
                        else begin m_mode = M_RUN; m_dir = m_pend; m_tgt = m_pdut; m_cur = 0; end
                    end
                end
                default: if (acc && cmd_dir != 2'd3) begin
                    m_mode = M_GAP; m_pend = cmd_dir; m_pdut = cmd_duty; m_gap = 0;
                end
            endcase
            drv = (m_mode == M_RUN || m_mode == M_SLOW);
            exp_o[5] = (drv && m_dir == 1) || m_mode == M_HOLD;
            exp_o[4] = (drv && m_dir == 2) || m_mode == M_HOLD;
            exp_o[3] = (m_mode == M_HOLD) || (drv && (ocyc % 256) < m_cur);
            exp_o[2] = (m_mode == M_SLOW || m_mode == M_GAP);
            exp_o[1] = (m_mode == M_OFF || m_mode == M_RUN || m_mode == M_HOLD);
            exp_o[0] = m_trip;
        end
        last_tick = tk;
        #1;
    endtask

    task automatic send(input logic [1:0] d, input logic [7:0] duty);
        cmd_dir = d; cmd_duty = duty; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        if (obs !== 6'b000010) begin bad++; $display("FAIL reset_outputs got=%b exp=000010", obs); end
        total++;
        if (dut.duty_cur_q !== 8'd0) begin bad++; $display("FAIL reset_duty got=%0d exp=0", dut.duty_cur_q); end
        total++;
        rst = 1'b0;
        step();
        if (obs !== exp_o) begin bad++; $display("FAIL reset_release got=%b exp=%b", obs, exp_o); end
        total++;
    endtask

    task automatic test_fwd_ramp();
        int exp_ramp[4] = '{64, 128, 192, 200};
        int k = 0;
        int on = 0;
        send(2'd1, 8'd200);
        if (obs !== exp_o) begin bad++; $display("FAIL fwd_accept got=%b exp=%b", obs, exp_o); end
        total++;
        for (int c = 0; c < 100 && k < 4; c++) begin
            step();
            if (obs !== exp_o) begin bad++; $display("FAIL fwd_vec got=%b exp=%b", obs, exp_o); end
            total++;
            if (last_tick) begin
                if (dut.duty_cur_q !== 8'(exp_ramp[k])) begin
                    bad++; $display("FAIL fwd_ramp[%0d] got=%0d exp=%0d", k, dut.duty_cur_q, exp_ramp[k]);
                end
                total++;
                k++;
            end
        end
        if (k != 4) begin bad++; $display("FAIL fwd_ramp_timeout got=%0d exp=4", k); end
        total++;
        for (int c = 0; c < 256; c++) begin
            step();
            if (obs !== exp_o) begin bad++; $display("FAIL fwd_steady got=%b exp=%b", obs, exp_o); end
            total++;
            on += int'(pwm);
        end
        if (on != 200) begin bad++; $display("FAIL fwd_pwm_ontime got=%0d exp=200", on); end
        total++;
        if ({in1, in2} !== 2'b10) begin bad++; $display("FAIL fwd_bridge got=%b exp=10", {in1, in2}); end
        total++;
    endtask

    task automatic test_reversal();
        int exp_dn[4] = '{136, 72, 8, 0};
        int k = 0;
        int low = 0;
        bit done = 0;
        send(2'd2, 8'd100);
        if ({busy, cmd_ready} !== 2'b10) begin bad++; $display("FAIL rev_busy got=%b exp=10", {busy, cmd_ready}); end
        total++;
        for (int c = 0; c < 400 && !done; c++) begin
            step();
            if (obs !== exp_o) begin bad++; $display("FAIL rev_vec got=%b exp=%b", obs, exp_o); end
            total++;
            if (last_tick && busy && k < 4) begin
                if (dut.duty_cur_q !== 8'(exp_dn[k])) begin
                    bad++; $display("FAIL rev_ramp[%0d] got=%0d exp=%0d", k, dut.duty_cur_q, exp_dn[k]);
                end
                total++;
                k++;
            end
            if (!in1 && !in2) low++;
            done = (m_mode == M_RUN && m_cur == 100);
        end
        if (!done || k != 4) begin bad++; $display("FAIL rev_timeout got=%0d exp=4", k); end
        total++;
        if (low != DT * TD) begin bad++; $display("FAIL rev_dead_cycles got=%0d exp=%0d", low, DT * TD); end
        total++;
        if ({in1, in2} !== 2'b01 || dut.duty_cur_q !== 8'd100) begin
            bad++; $display("FAIL rev_final got=%b/%0d exp=01/100", {in1, in2}, dut.duty_cur_q);
        end
        total++;
    endtask

    task automatic test_brake();
        int n = 0;
        rst = 1'b1; step(); rst = 1'b0;
        send(2'd1, 8'd128);
        for (int c = 0; c < 100 && m_cur != 128; c++) begin
            step();
            if (obs !== exp_o) begin bad++; $display("FAIL brake_pre got=%b exp=%b", obs, exp_o); end
            total++;
        end
        send(2'd3, 8'd0);
        if ({in1, in2, pwm} !== 3'b000) begin bad++; $display("FAIL brake_cut got=%b exp=000", {in1, in2, pwm}); end
        total++;
        for (int c = 0; c < 40 && !(in1 && in2); c++) begin
            step(); n++;
            if (obs !== exp_o) begin bad++; $display("FAIL brake_vec got=%b exp=%b", obs, exp_o); end
            total++;
        end
        if ({in1, in2, pwm} !== 3'b111 || n > DT * TD) begin
            bad++; $display("FAIL brake_on got=%b after %0d exp=111 within %0d", {in1, in2, pwm}, n, DT * TD);
        end
        total++;
        for (int c = 0; c < 20; c++) begin
            step();
            if (obs !== exp_o) begin bad++; $display("FAIL brake_hold got=%b exp=%b", obs, exp_o); end
            total++;
        end
    endtask

    task automatic test_hold_valid();
        bit got = 0;
        int acc_mode = -1;
        send(2'd1, 8'd50);
        for (int c = 0; c < 100 && m_mode != M_RUN; c++) begin
            step();
            if (obs !== exp_o) begin bad++; $display("FAIL hold_exit_brake got=%b exp=%b", obs, exp_o); end
            total++;
        end
        send(2'd0, 8'd0);
        cmd_dir = 2'd1; cmd_duty = 8'd50; cmd_valid = 1'b1;
        for (int c = 0; c < 200 && !got; c++) begin
            step();
            if (obs !== exp_o) begin bad++; $display("FAIL hold_vec got=%b exp=%b", obs, exp_o); end
            total++;
            if (acc_dut) begin got = 1; acc_mode = pre_mode; end
        end
        cmd_valid = 1'b0;
        if (!got || acc_mode != M_OFF) begin
            bad++; $display("FAIL hold_accept got=%0d/%0d exp=1/%0d", got, acc_mode, M_OFF);
        end
        total++;
        for (int c = 0; c < 30; c++) begin
            step();
            if (obs !== exp_o) begin bad++; $display("FAIL hold_run got=%b exp=%b", obs, exp_o); end
            total++;
        end
        if (in1 !== 1'b1 || dut.duty_cur_q !== 8'd50) begin
            bad++; $display("FAIL hold_final got=%b/%0d exp=1/50", in1, dut.duty_cur_q);
        end
        total++;
    endtask

    task automatic test_reset_mid();
        send(2'd2, 8'd255);
        step(); step();
        if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy got=%b exp=1", busy); end
        total++;
        rst = 1'b1; step(); rst = 1'b0;
        if (obs !== 6'b000010 || dut.duty_cur_q !== 8'd0) begin
            bad++; $display("FAIL rstmid_outputs got=%b/%0d exp=000010/0", obs, dut.duty_cur_q);
        end
        total++;
        step();
        if (obs !== exp_o) begin bad++; $display("FAIL rstmid_after got=%b exp=%b", obs, exp_o); end
        total++;
    endtask

    task automatic test_random();
        int rate = 10;
        for (int c = 0; c < 3000; c++) begin
            if (c % 256 == 0) rate = (c % 768 == 0) ? 3 : ((c % 512 == 0) ? 80 : 12);
            rst       = ($urandom_range(0, 599) == 0);
            cmd_valid = ($urandom_range(0, rate - 1) == 0);
            cmd_dir   = 2'($urandom_range(0, 3));
            cmd_duty  = 8'($urandom_range(0, 255));
            step();
            if (obs !== exp_o) begin bad++; $display("FAIL random[%0d] got=%b exp=%b", c, obs, exp_o); end
            total++;
        end
        rst = 1'b0; cmd_valid = 1'b0;
    endtask

    task automatic test_wdog();
        int ticks = 0;
        bit tripped = 0;
        bit idle = 0;
        rst = 1'b1; step(); rst = 1'b0;
        send(2'd1, 8'd255);
`ifdef MOTOR_WDOG_EN
        for (int c = 0; c < 200 && !tripped; c++) begin
            step();
            if (obs !== exp_o) begin bad++; $display("FAIL wdog_vec got=%b exp=%b", obs, exp_o); end
            total++;
            if (last_tick) ticks++;
            tripped = wdog_trip;
        end
        if (!tripped || ticks != WT) begin bad++; $display("FAIL wdog_ticks got=%0d exp=%0d", ticks, WT); end
        total++;
        for (int c = 0; c < 200 && !idle; c++) begin
            step();
            if (obs !== exp_o) begin bad++; $display("FAIL wdog_stop got=%b exp=%b", obs, exp_o); end
            total++;
            idle = cmd_ready && !busy && !in1 && !in2;
        end
        if (!idle || wdog_trip !== 1'b1) begin bad++; $display("FAIL wdog_idle got=%0d/%b exp=1/1", idle, wdog_trip); end
        total++;
        send(2'd1, 8'd20);
        if (wdog_trip !== 1'b0 || in1 !== 1'b1) begin
            bad++; $display("FAIL wdog_clear got=%b/%b exp=0/1", wdog_trip, in1);
        end
        total++;
`else
        for (int c = 0; c < 400; c++) begin
            step();
            if (obs !== exp_o) begin bad++; $display("FAIL nowdog_vec got=%b exp=%b", obs, exp_o); end
            total++;
            if (last_tick) ticks++;
        end
        if (wdog_trip !== 1'b0 || in1 !== 1'b1 || ticks != 100) begin
            bad++; $display("FAIL nowdog_run got=%b/%b/%0d exp=0/1/100", wdog_trip, in1, ticks);
        end
        total++;
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        #1;
        test_reset();
        test_fwd_ramp();
        test_reversal();
        test_brake();
        test_hold_valid();
        test_reset_mid();
        test_random();
        test_wdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
